// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: line-granular write buffer between the L2 memory-side master and physical memory.
// Absorbs evictions, serves read hits, and drains lines in FIFO order when idle or full.
module l2_writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [11:0]                  up_adr,
  input  logic [127:0]                 up_dat_m,
  output logic [127:0]                 up_dat_s,
  input  logic                         up_we,
  input  logic                         up_stb,
  input  logic                         up_cyc,
  output logic                         up_ack,
  output logic                         up_rty,
  output logic [11:0]                  dn_adr,
  output logic [127:0]                 dn_dat_m,
  input  logic [127:0]                 dn_dat_s,
  output logic                         dn_we,
  output logic                         dn_stb,
  output logic                         dn_cyc,
  output logic [15:0]                  dn_sel,
  input  logic                         dn_ack,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, DN_READ, ACK} state_t;
  state_t           state;
  logic [DEPTH-1:0] vld;
  logic [11:0]      adr_q [DEPTH];
  logic [127:0]     dat_q [DEPTH];
  logic [PW-1:0]    head, tail, hit_idx;
  logic             hit, req, start_drain;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign req         = up_stb & up_cyc;
  assign up_rty      = req & ~up_ack;
  assign dn_cyc      = dn_stb;
  assign dn_sel      = 16'hFFFF;
  // a full-buffer write miss drains the oldest line, then the request is re-sampled
  assign start_drain = req ? (up_we & ~hit & full) : ~empty;
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && adr_q[i] == up_adr) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      vld       <= '0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      up_ack    <= 1'b0;
      up_dat_s  <= '0;
      dn_stb    <= 1'b0;
      dn_we     <= 1'b0;
      dn_adr    <= '0;
      dn_dat_m  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      up_ack <= 1'b0;
      case (state)
        IDLE:
          if (start_drain) begin
            dn_stb   <= 1'b1;
            dn_we    <= 1'b1;
            dn_adr   <= adr_q[head];
            dn_dat_m <= dat_q[head];
            state    <= DRAIN;
          end else if (req) begin
            if (up_we && hit) begin
              dat_q[hit_idx] <= up_dat_m;
              up_ack         <= 1'b1;
              state          <= ACK;
            end else if (up_we) begin
              vld[tail]   <= 1'b1;
              adr_q[tail] <= up_adr;
              dat_q[tail] <= up_dat_m;
              tail        <= nxt(tail);
              occupancy   <= occupancy + 1'b1;
              full        <= occupancy == OW'(DEPTH - 1);
              empty       <= 1'b0;
              up_ack      <= 1'b1;
              state       <= ACK;
            end else if (hit) begin
              up_dat_s <= dat_q[hit_idx];
              up_ack   <= 1'b1;
              state    <= ACK;
            end else begin
              dn_stb <= 1'b1;
              dn_we  <= 1'b0;
              dn_adr <= up_adr;
              state  <= DN_READ;
            end
          end
        DRAIN:
          if (dn_ack) begin
            dn_stb    <= 1'b0;
            dn_we     <= 1'b0;
            vld[head] <= 1'b0;
            head      <= nxt(head);
            occupancy <= occupancy - 1'b1;
            full      <= 1'b0;
            empty     <= occupancy == OW'(1);
            state     <= IDLE;
          end
        DN_READ:
          if (dn_ack) begin
            dn_stb   <= 1'b0;
            up_dat_s <= dn_dat_s;
            up_ack   <= 1'b1;
            state    <= ACK;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
